// File: rtl/calc_engine.sv
// Multi-cycle arithmetic engine: add, sub, shift-add mult, restoring div,
// subtractive gcd, trial-division primality and incremental integer sqrt.
module calc_engine (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        add,
  input  logic        sub,
  input  logic        div,
  input  logic        mult,
  input  logic        gcd,
  input  logic        isprime,
  input  logic        sqrt,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Result,
  output logic [7:0]  Rem,
  output logic        Err,
  output logic        Neg
);

  localparam int unsigned DW   = 8;
  localparam int unsigned RW   = 16;
  localparam int unsigned CW   = 5;
  localparam int unsigned NOPS = 7;
  localparam int unsigned SQW  = 10;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_DIV  = 2;
  localparam int unsigned OP_MULT = 3;
  localparam int unsigned OP_GCD  = 4;
  localparam int unsigned OP_PRIM = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, rw_q, rw_d;
  logic [NOPS-1:0] op_q, op_d;
  logic            ill_q, ill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   result_q, result_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            err_q, err_d, neg_q, neg_d, busy_q, busy_d, done_q, done_d;

  logic [NOPS-1:0] sel_c;
  logic            sel_legal_c;
  logic [RW-1:0]   mul_pp_c, mul_sum_c;
  logic [DW:0]     div_sh_c;
  logic            div_ge_c;
  logic [DW-1:0]   div_nx_c;
  logic [CW-1:0]   pr_d_c, sq_r1_c;
  logic [SQW-1:0]  pr_sq_c, sq_sq_c;
  logic [DW-1:0]   pr_mod_c;
  logic            fin_c, ferr_c, fneg_c;
  logic [RW-1:0]   fres_c;
  logic [DW-1:0]   frem_c;

  assign sel_c       = {sqrt, isprime, gcd, mult, div, sub, add};
  assign sel_legal_c = (sel_c != '0) && ((sel_c & (sel_c - NOPS'(1))) == '0);

  // Per-iteration datapath for the multi-cycle ops
  assign mul_pp_c  = b_q[cnt_q[2:0]] ? (RW'(a_q) << cnt_q[2:0]) : '0;
  assign mul_sum_c = acc_q + mul_pp_c;
  assign div_sh_c  = {rw_q, a_q[DW-1]};
  assign div_ge_c  = div_sh_c >= {1'b0, b_q};
  assign div_nx_c  = div_ge_c ? DW'(div_sh_c - {1'b0, b_q}) : div_sh_c[DW-1:0];
  assign pr_d_c    = cnt_q + CW'(2);
  assign pr_sq_c   = SQW'(pr_d_c) * SQW'(pr_d_c);
  assign pr_mod_c  = a_q % DW'(pr_d_c);
  assign sq_r1_c   = cnt_q + CW'(1);
  assign sq_sq_c   = SQW'(sq_r1_c) * SQW'(sq_r1_c);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rw_d     = rw_q;
    result_d = result_q;
    rem_d    = rem_q;
    err_d    = err_q;
    neg_d    = neg_q;
    fin_c    = 1'b0;
    fres_c   = '0;
    frem_c   = '0;
    ferr_c   = 1'b0;
    fneg_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CALC;
          a_d     = A;
          b_d     = B;
          op_d    = sel_c;
          ill_d   = !sel_legal_c;
          cnt_d   = '0;
          acc_d   = '0;
          rw_d    = '0;
        end
      end
      CALC: begin
        if (ill_q) begin
          fin_c  = 1'b1;
          ferr_c = 1'b1;
        end else if (op_q[OP_ADD]) begin
          fin_c  = 1'b1;
          fres_c = RW'(a_q) + RW'(b_q);
        end else if (op_q[OP_SUB]) begin
          fin_c  = 1'b1;
          fres_c = {8'b0, DW'(a_q - b_q)};
          fneg_c = b_q > a_q;
        end else if (op_q[OP_MULT]) begin
          acc_d = mul_sum_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) begin
            fin_c  = 1'b1;
            fres_c = mul_sum_c;
          end
        end else if (op_q[OP_DIV]) begin
          if (b_q == '0) begin
            fin_c  = 1'b1;
            ferr_c = 1'b1;
            fres_c = '1;
            frem_c = a_q;
          end else begin
            a_d   = {a_q[DW-2:0], div_ge_c};
            rw_d  = div_nx_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
              fin_c  = 1'b1;
              fres_c = {8'b0, a_q[DW-2:0], div_ge_c};
              frem_c = div_nx_c;
            end
          end
        end else if (op_q[OP_GCD]) begin
          // A zero operand ends immediately; otherwise subtract until equal
          if (a_q == '0 || b_q == '0) begin
            fin_c  = 1'b1;
            fres_c = RW'(a_q | b_q);
          end else if (a_q == b_q) begin
            fin_c  = 1'b1;
            fres_c = RW'(a_q);
          end else if (a_q > b_q) begin
            a_d = a_q - b_q;
          end else begin
            b_d = b_q - a_q;
          end
        end else if (op_q[OP_PRIM]) begin
          if (a_q < DW'(2)) begin
            fin_c = 1'b1;
          end else if (pr_sq_c > SQW'(a_q) || pr_d_c > CW'(15)) begin
            fin_c  = 1'b1;
            fres_c = RW'(1);
          end else if (pr_mod_c == '0) begin
            fin_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          if (sq_sq_c <= SQW'(a_q)) begin
            cnt_d = sq_r1_c;
          end else begin
            fin_c  = 1'b1;
            fres_c = RW'(cnt_q);
          end
        end
        if (fin_c) begin
          state_d  = FIN;
          result_d = fres_c;
          rem_d    = frem_c;
          err_d    = ferr_c;
          neg_d    = fneg_c;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rw_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rw_q     <= rw_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Rem    = rem_q;
  assign Err    = err_q;
  assign Neg    = neg_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine with hand-computed expected values.
module tb_calc_engine;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        add = 1'b0, sub = 1'b0, div = 1'b0, mult = 1'b0;
  logic        gcd = 1'b0, isprime = 1'b0, sqrt = 1'b0;
  logic [7:0]  A = '0, B = '0;
  logic        Busy, Done, Err, Neg;
  logic [15:0] Result;
  logic [7:0]  Rem;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] S_ADD = 7'b0000001, S_SUB = 7'b0000010, S_DIV = 7'b0000100,
                         S_MUL = 7'b0001000, S_GCD = 7'b0010000, S_PRI = 7'b0100000,
                         S_SQR = 7'b1000000;

  calc_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .add(add), .sub(sub), .div(div), .mult(mult), .gcd(gcd), .isprime(isprime), .sqrt(sqrt),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result), .Rem(Rem), .Err(Err), .Neg(Neg)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op; lat = cycle of Done counting the Start cycle as 0.
  task automatic run_op(input logic [6:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input bit poke, output logic [15:0] res, output logic [7:0] rem,
                        output logic err, output logic neg, output int lat, output int busy_n);
    bit got = 0;
    int overlap = 0;
    @(negedge Clk);
    {sqrt, isprime, gcd, mult, div, sub, add} = sel;
    A = a; B = b; Start = 1'b1;
    busy_n = 0;
    res = '0; rem = '0; err = 1'b0; neg = 1'b0;
    @(negedge Clk);
    lat = 1;
    {sqrt, isprime, gcd, mult, div, sub, add} = '0;
    A = ~a; B = ~b;
    Start = poke;
    while (!got && lat < 400) begin
      if (Busy) busy_n++;
      if (Busy && Done) overlap++;
      if (Done) begin
        res = Result; rem = Rem; err = Err; neg = Neg;
        got = 1;
      end else begin
        @(negedge Clk);
        lat++;
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("busy_done_overlap", 32'(overlap), 32'd0);
  endtask

  logic [15:0] r;
  logic [7:0]  m;
  logic        e, n;
  int          lat, bn, seen;

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_flags", 32'({Rem, Err, Neg}), 32'd0);
    Reset = 1'b1;

    run_op(S_MUL, 8'hFF, 8'hFF, 0, r, m, e, n, lat, bn);
    check("mult_ff_res", 32'(r), 32'hFE01);
    check("mult_ff_lat", 32'(lat), 32'd9);
    check("mult_ff_busy", 32'(bn), 32'd8);
    check("mult_ff_rem_err", 32'({m, e}), 32'd0);
    run_op(S_MUL, 8'd13, 8'd11, 0, r, m, e, n, lat, bn);
    check("mult_13x11", 32'(r), 32'd143);

    run_op(S_DIV, 8'd200, 8'd7, 0, r, m, e, n, lat, bn);
    check("div_200_7_q", 32'(r), 32'd28);
    check("div_200_7_r", 32'(m), 32'd4);
    check("div_200_7_lat", 32'(lat), 32'd9);
    check("div_200_7_err", 32'(e), 32'd0);
    run_op(S_DIV, 8'd9, 8'd0, 0, r, m, e, n, lat, bn);
    check("div0_err", 32'(e), 32'd1);
    check("div0_res", 32'(r), 32'hFFFF);
    check("div0_rem", 32'(m), 32'd9);
    check("div0_lat", 32'(lat), 32'd2);

    run_op(S_GCD, 8'd48, 8'd18, 0, r, m, e, n, lat, bn);
    check("gcd_48_18", 32'(r), 32'd6);
    check("gcd_rem", 32'(m), 32'd0);
    run_op(S_GCD, 8'd0, 8'd35, 0, r, m, e, n, lat, bn);
    check("gcd_0_35", 32'(r), 32'd35);
    check("gcd_0_35_lat", 32'(lat), 32'd2);
    run_op(S_GCD, 8'd0, 8'd0, 0, r, m, e, n, lat, bn);
    check("gcd_0_0", 32'(r), 32'd0);
    run_op(S_GCD, 8'd1, 8'd255, 0, r, m, e, n, lat, bn);
    check("gcd_1_255", 32'(r), 32'd1);
    check("gcd_1_255_bound", 32'(bn <= 256), 32'd1);

    run_op(S_PRI, 8'd251, 8'd0, 0, r, m, e, n, lat, bn);
    check("prime_251", 32'(r), 32'd1);
    check("prime_251_bound", 32'(bn <= 128), 32'd1);
    run_op(S_PRI, 8'd221, 8'd0, 0, r, m, e, n, lat, bn);
    check("prime_221", 32'(r), 32'd0);
    run_op(S_PRI, 8'd1, 8'd0, 0, r, m, e, n, lat, bn);
    check("prime_1", 32'(r), 32'd0);
    check("prime_1_lat", 32'(lat), 32'd2);
    run_op(S_PRI, 8'd2, 8'd0, 0, r, m, e, n, lat, bn);
    check("prime_2", 32'(r), 32'd1);
    run_op(S_PRI, 8'd4, 8'd0, 0, r, m, e, n, lat, bn);
    check("prime_4", 32'(r), 32'd0);

    run_op(S_SQR, 8'd255, 8'd0, 0, r, m, e, n, lat, bn);
    check("sqrt_255", 32'(r), 32'd15);
    check("sqrt_255_bound", 32'(bn <= 17), 32'd1);
    run_op(S_SQR, 8'd16, 8'd0, 0, r, m, e, n, lat, bn);
    check("sqrt_16", 32'(r), 32'd4);
    run_op(S_SQR, 8'd0, 8'd0, 0, r, m, e, n, lat, bn);
    check("sqrt_0", 32'(r), 32'd0);

    // Second Start pulse while busy must be ignored
    run_op(S_SUB, 8'd5, 8'd9, 1, r, m, e, n, lat, bn);
    check("sub_5_9", 32'(r), 32'h00FC);
    check("sub_5_9_neg", 32'(n), 32'd1);
    @(negedge Clk);
    check("sub_poke_idle", 32'({Busy, Done}), 32'd0);
    run_op(S_ADD, 8'h0A, 8'hDD, 1, r, m, e, n, lat, bn);
    check("add_0a_dd", 32'(r), 32'h00E7);
    check("add_neg_clr", 32'(n), 32'd0);
    @(negedge Clk);
    check("add_poke_idle", 32'({Busy, Done}), 32'd0);
    run_op(S_ADD, 8'hFF, 8'hFF, 0, r, m, e, n, lat, bn);
    check("add_carry", 32'(r), 32'h01FE);
    // Back-to-back: next Start lands in the IDLE cycle right after FIN
    run_op(S_SUB, 8'd9, 8'd5, 0, r, m, e, n, lat, bn);
    check("b2b_sub", 32'(r), 32'd4);
    check("b2b_sub_neg", 32'(n), 32'd0);

    run_op(S_ADD | S_SUB, 8'd3, 8'd4, 0, r, m, e, n, lat, bn);
    check("illegal_err", 32'(e), 32'd1);
    check("illegal_res", 32'({r, m, n}), 32'd0);
    check("illegal_lat", 32'(lat), 32'd2);
    run_op(7'b0, 8'd3, 8'd4, 0, r, m, e, n, lat, bn);
    check("nosel_err", 32'(e), 32'd1);

    run_op(S_MUL, 8'd3, 8'd3, 0, r, m, e, n, lat, bn);
    // Abort a long gcd with reset mid-CALC
    @(negedge Clk);
    {gcd, A, B, Start} = {1'b1, 8'd1, 8'd255, 1'b1};
    @(negedge Clk);
    {gcd, Start} = '0;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_busy_done", 32'({Busy, Done}), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    check("abort_flags", 32'({Rem, Err, Neg}), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge Clk);
      if (Done || Busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(S_ADD, 8'd1, 8'd2, 0, r, m, e, n, lat, bn);
    check("post_abort_add", 32'(r), 32'd3);
    check("post_abort_lat", 32'(lat), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 The port list SHALL use one clock and one reset: the clock port is Clk and the reset port is Reset; Reset is asynchronous and active-low.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 Start  input  1  single-cycle request pulse from the menu control unit.
REQ-005 add, sub, div, mult, gcd, isprime, sqrt  input  1 each  one-hot operation select, driven by the control unit's state outputs.
REQ-006 A  input  8  operand 1 (num1), unsigned.
REQ-007 B  input  8  operand 2 (num2), unsigned; ignored by isprime and sqrt.
REQ-008 Busy  output  1  high while a computation is in progress.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Result  output  16  primary result; holds value until the next accepted Start.
REQ-011 Rem  output  8  remainder (div only; 0 for all other ops).
REQ-012 Err  output  1  divide by zero or illegal select; valid with Done, held like Result.
REQ-013 Neg  output  1  sub borrow flag (B > A); held like Result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, FIN. IDLE->CALC on Start; CALC->FIN on op complete; FIN->IDLE unconditionally.
REQ-015 Start SHALL be accepted only in IDLE; Start in CALC or FIN is ignored with no effect.
REQ-016 On acceptance, the block SHALL latch A, B and the op select; later input changes do not affect the running op.
REQ-017 If zero or more than one select bit is high at acceptance, the block SHALL go to FIN next cycle with Err=1, Result=0, Rem=0, Neg=0.
REQ-018 Busy SHALL be 1 in CALC only; Done SHALL be 1 in FIN only; they are never high together.
REQ-019 Result, Rem, Err and Neg SHALL update on the CALC->FIN edge and be stable while Done=1.
REQ-020 add: Result={7'b0, A+B} with a 9-bit sum; 1 CALC cycle.
REQ-021 sub: Result={8'b0, (A-B) mod 256}; Neg=1 if B>A; 1 CALC cycle.
REQ-022 mult: shift-add, one partial product per cycle; Result=A*B (16 bits); exactly 8 CALC cycles.
REQ-023 div: restoring division, one quotient bit per cycle; Result={8'b0, A/B}, Rem=A%B; exactly 8 CALC cycles.
REQ-024 div with B=0: 1 CALC cycle; Err=1, Result=16'hFFFF, Rem=A.
REQ-025 gcd: subtractive Euclid, one subtract per cycle (larger minus smaller) until the two operands are equal; Result=gcd.
REQ-026 gcd zero cases: 1 CALC cycle; if either operand is 0, Result is the other operand; gcd(0,0)=0.
REQ-027 gcd latency SHALL never exceed 256 CALC cycles.
REQ-028 isprime: Result=1 if A is prime, else 0.
REQ-029 isprime with A<2: Result=0 in 1 CALC cycle.
REQ-030 isprime with A>=2: trial divisors d=2,3,...,15, one iteration per cycle. Stop with Result=0 at the first d<A with A mod d==0. Stop with Result=1 when d*d>A or d>15. Latency SHALL never exceed 128 CALC cycles.
REQ-031 sqrt: Result=floor(sqrt(A)) via an incrementing root r while (r+1)^2<=A, one step per cycle; latency is at most 17 CALC cycles.
REQ-032 Back-to-back operation: Start asserted in the cycle after FIN (i.e., in IDLE) SHALL be accepted.

Reset
REQ-033 While Reset=0, the block SHALL hold: state=IDLE, Busy=0, Done=0, Result=0, Rem=0, Err=0, Neg=0, and all internal registers cleared.
REQ-034 Reset asserted mid-CALC SHALL abort the operation; no Done pulse follows release; the first Start after release is accepted normally.

Verification
REQ-035 mult, A=8'hFF, B=8'hFF, Start at cycle 0: Busy cycles 1-8, Done cycle 9, Result=16'hFE01.
REQ-036 div, A=200, B=7: Done after 8 CALC cycles, Result=28, Rem=4. Then div with B=0, A=9: Err=1, Result=16'hFFFF, Rem=9, Done 2 cycles after Start.
REQ-037 gcd: A=48, B=18 gives Result=6. A=0, B=35 gives Result=35. A=1, B=255 gives Result=1 within 256 CALC cycles.
REQ-038 isprime: A=251 gives Result=1; A=221 gives Result=0; A=1 gives Result=0; A=2 gives Result=1. sqrt: A=255 gives Result=15; A=0 gives Result=0.
REQ-039 sub, A=5, B=9: Result=16'h00FC, Neg=1. add, A=8'h0A, B=8'hDD: Result=16'h00E7. Both with Start pulsed again during Busy: second pulse is ignored.
REQ-040 Illegal select: add=1 and sub=1 with Start gives Err=1, Result=0, Done on cycle 2. Reset low during gcd CALC gives all outputs 0 immediately and no Done.
